// File: rtl/mouse_packet_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mouse_packet_ctrl_if
// Purpose  : Transceiver-side and cursor-side signal bundle of mouse_packet_ctrl
// Revision : 1.0  initial release
// ============================================================================
interface mouse_packet_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_busy;
  logic [7:0] tx_cmd;
  logic       tx_send;
  logic [8:0] x;
  logic [8:0] y;
  logic       left_click;
  logic       right_click;
  logic       pkt_valid;
  logic [1:0] cState;

  modport master (
    input  rx_data, rx_valid, tx_busy,
    output tx_cmd, tx_send, x, y, left_click, right_click, pkt_valid, cState
  );

  modport slave (
    output rx_data, rx_valid, tx_busy,
    input  tx_cmd, tx_send, x, y, left_click, right_click, pkt_valid, cState
  );
endinterface
`default_nettype wire

// File: rtl/mouse_packet_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mouse_packet_ctrl
// Purpose  : PS/2 mouse init (F4/FA) and 3-byte packet to clamped cursor.
//            Optional idle timeout enabled by defining MOUSE_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module mouse_packet_ctrl #(
  parameter int X_MAX   = 319,
  parameter int Y_MAX   = 239,
  parameter int X_INIT  = 160,
  parameter int Y_INIT  = 120,
  parameter int TIMEOUT = 100000
) (
  input  wire logic             CLOCK_50,
  input  wire logic             reset,
  mouse_packet_ctrl_if.master   mif
);

  typedef enum logic [1:0] {
    ST_SEND   = 2'b00,
    ST_ACK    = 2'b01,
    ST_STREAM = 2'b10,
    ST_UNUSED = 2'b11
  } state_e;

  localparam logic signed [10:0] X_MAX_C = 11'(X_MAX);
  localparam logic signed [10:0] Y_MAX_C = 11'(Y_MAX);

  state_e      state_q;
  logic [1:0]  idx_q;
  logic        left_pend_q, right_pend_q;
  logic        xs_q, ys_q, xo_q, yo_q;
  logic [7:0]  dxl_q;
  logic [8:0]  x_q, y_q;
  logic        left_q, right_q, pkt_valid_q, tx_send_q;

  logic [8:0]         x_d, y_d;
  logic signed [10:0] nx_w, ny_w;
  logic               timeout_w;

  // Byte 2 is consumed straight off rx_data so the packet lands one cycle later.
  always_comb begin
    nx_w = $signed({2'b00, x_q}) + $signed({{2{xs_q}}, xs_q, dxl_q});
    ny_w = $signed({2'b00, y_q}) - $signed({{2{ys_q}}, ys_q, mif.rx_data});
    x_d  = x_q;
    y_d  = y_q;
    if (!(xo_q || yo_q)) begin
      if (nx_w < 0)             x_d = 9'd0;
      else if (nx_w > X_MAX_C)  x_d = X_MAX_C[8:0];
      else                      x_d = nx_w[8:0];
      if (ny_w < 0)             y_d = 9'd0;
      else if (ny_w > Y_MAX_C)  y_d = Y_MAX_C[8:0];
      else                      y_d = ny_w[8:0];
    end
  end

`ifdef MOUSE_TIMEOUT_EN
  localparam logic [16:0] TO_C = 17'(TIMEOUT);
  logic [16:0] idle_q;

  assign timeout_w = (idle_q >= TO_C);

  // Every state change is either an rx_valid, a timeout, or leaves a
  // non-counting state, so the final else-clear covers all of them.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      idle_q <= '0;
    end else if (mif.rx_valid || timeout_w) begin
      idle_q <= '0;
    end else if (state_q == ST_ACK || (state_q == ST_STREAM && idx_q != 2'd0)) begin
      idle_q <= idle_q + 17'd1;
    end else begin
      idle_q <= '0;
    end
  end
`else
  logic timeout_unused;
  assign timeout_w      = 1'b0;
  assign timeout_unused = ^17'(TIMEOUT);
`endif

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= ST_SEND;
      idx_q        <= 2'd0;
      left_pend_q  <= 1'b0;
      right_pend_q <= 1'b0;
      xs_q         <= 1'b0;
      ys_q         <= 1'b0;
      xo_q         <= 1'b0;
      yo_q         <= 1'b0;
      dxl_q        <= 8'd0;
      x_q          <= 9'(X_INIT);
      y_q          <= 9'(Y_INIT);
      left_q       <= 1'b0;
      right_q      <= 1'b0;
      pkt_valid_q  <= 1'b0;
      tx_send_q    <= 1'b0;
    end else begin
      tx_send_q   <= 1'b0;
      pkt_valid_q <= 1'b0;
      case (state_q)
        ST_SEND: begin
          idx_q <= 2'd0;
          if (!mif.tx_busy) begin
            tx_send_q <= 1'b1;
            state_q   <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (mif.rx_valid) begin
            state_q <= (mif.rx_data == 8'hFA) ? ST_STREAM : ST_SEND;
          end else if (timeout_w) begin
            state_q <= ST_SEND;
          end
        end
        ST_STREAM: begin
          if (mif.rx_valid) begin
            case (idx_q)
              2'd0: begin
                // AA is checked first: it also has bit3 set.
                if (mif.rx_data == 8'hAA) begin
                  state_q <= ST_SEND;
                end else if (mif.rx_data[3]) begin
                  left_pend_q  <= mif.rx_data[0];
                  right_pend_q <= mif.rx_data[1];
                  xs_q         <= mif.rx_data[4];
                  ys_q         <= mif.rx_data[5];
                  xo_q         <= mif.rx_data[6];
                  yo_q         <= mif.rx_data[7];
                  idx_q        <= 2'd1;
                end
              end
              2'd1: begin
                dxl_q <= mif.rx_data;
                idx_q <= 2'd2;
              end
              default: begin
                x_q         <= x_d;
                y_q         <= y_d;
                left_q      <= left_pend_q;
                right_q     <= right_pend_q;
                pkt_valid_q <= 1'b1;
                idx_q       <= 2'd0;
              end
            endcase
          end else if (timeout_w) begin
            idx_q <= 2'd0;
          end
        end
        default: state_q <= ST_SEND;
      endcase
    end
  end

  assign mif.tx_cmd      = 8'hF4;
  assign mif.tx_send     = tx_send_q;
  assign mif.x           = x_q;
  assign mif.y           = y_q;
  assign mif.left_click  = left_q;
  assign mif.right_click = right_q;
  assign mif.pkt_valid   = pkt_valid_q;
  assign mif.cState      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mouse_packet_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mouse_packet_ctrl
// Purpose  : Directed bench for mouse_packet_ctrl with packet scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_mouse_packet_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  typedef struct {
    int x;
    int y;
    int l;
    int r;
  } exp_t;

  exp_t exp_q[$];

  mouse_packet_ctrl_if mif();

  mouse_packet_ctrl #(
    .X_MAX   (319),
    .Y_MAX   (239),
    .X_INIT  (160),
    .Y_INIT  (120),
    .TIMEOUT (100)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .mif      (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int x, input int y, input int l, input int r);
    exp_t e;
    e.x = x; e.y = y; e.l = l; e.r = r;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    mif.rx_data  = b;
    mif.rx_valid = 1'b1;
    @(negedge clk);
    mif.rx_valid = 1'b0;
  endtask

  // Three bytes on consecutive cycles.
  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    @(negedge clk);
    mif.rx_data = b0; mif.rx_valid = 1'b1;
    @(negedge clk);
    mif.rx_data = b1;
    @(negedge clk);
    mif.rx_data = b2;
    @(negedge clk);
    mif.rx_valid = 1'b0;
  endtask

  // Scoreboard monitor: every pkt_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && mif.pkt_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pkt_unexpected: got x=%0d y=%0d expected no packet", mif.x, mif.y);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (mif.x != 9'(e.x) || mif.y != 9'(e.y) ||
            mif.left_click != e.l[0] || mif.right_click != e.r[0]) begin
          errors++;
          $display("FAIL pkt: got x=%0d y=%0d l=%0d r=%0d expected x=%0d y=%0d l=%0d r=%0d",
                   mif.x, mif.y, mif.left_click, mif.right_click, e.x, e.y, e.l, e.r);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic expect_resend();
    chk("resend_state", int'(mif.cState), 0);
    @(negedge clk);
    chk("resend_tx_send", int'(mif.tx_send), 1);
    chk("resend_ack_state", int'(mif.cState), 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    mif.rx_data  = 8'h00;
    mif.rx_valid = 1'b0;
    mif.tx_busy  = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cState", int'(mif.cState), 0);
    chk("rst_tx_send", int'(mif.tx_send), 0);
    chk("rst_x", int'(mif.x), 160);
    chk("rst_y", int'(mif.y), 120);
    chk("rst_buttons", int'({mif.left_click, mif.right_click}), 0);
    chk("rst_pkt_valid", int'(mif.pkt_valid), 0);
    chk("tx_cmd", int'(mif.tx_cmd), 8'hF4);
    rst = 1'b0;

    // Busy transceiver holds off the command.
    repeat (2) @(negedge clk);
    chk("busy_wait_state", int'(mif.cState), 0);
    chk("busy_wait_tx_send", int'(mif.tx_send), 0);
    mif.tx_busy = 1'b0;
    @(negedge clk);
    chk("init_tx_send", int'(mif.tx_send), 1);
    chk("init_ack_state", int'(mif.cState), 1);
    @(negedge clk);
    chk("tx_send_one_cycle", int'(mif.tx_send), 0);

    send_byte(8'hFE);
    expect_resend();
    send_byte(8'hFA);
    chk("stream_state", int'(mif.cState), 2);

    push(165, 117, 0, 0);
    send_pkt(8'h08, 8'h05, 8'h03);
    chk("latency_pkt_valid", int'(mif.pkt_valid), 1);
    @(negedge clk);
    chk("pkt_valid_one_cycle", int'(mif.pkt_valid), 0);

    push(292, 117, 1, 0);
    push(319, 117, 1, 0);
    push(319, 117, 1, 0);
    repeat (3) send_pkt(8'h09, 8'h7F, 8'h00);
    push(63, 117, 0, 0);
    push(0, 117, 0, 0);
    repeat (2) send_pkt(8'h18, 8'h00, 8'h00);

    send_byte(8'h00);
    push(0, 116, 0, 1);
    send_pkt(8'h0A, 8'h00, 8'h01);
    push(0, 116, 0, 0);
    send_pkt(8'h48, 8'h10, 8'h10);
    push(0, 239, 0, 0);
    send_pkt(8'h28, 8'h00, 8'h80);
    chk("y_clamp", int'(mif.y), 239);

    send_byte(8'hAA);
    expect_resend();
    send_byte(8'hFA);
    push(1, 239, 0, 0);
    send_pkt(8'h08, 8'h01, 8'h00);

`ifdef MOUSE_TIMEOUT_EN
    send_byte(8'h08);
    send_byte(8'h05);
    repeat (120) @(negedge clk);
    push(2, 238, 0, 0);
    send_pkt(8'h08, 8'h01, 8'h01);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    // Reset mid-packet discards the partial packet.
    send_byte(8'h08);
    send_byte(8'h05);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_x", int'(mif.x), 160);
    chk("midrst_y", int'(mif.y), 120);
    chk("midrst_state", int'(mif.cState), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_tx_send", int'(mif.tx_send), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mouse_packet_ctrl.md
# mouse_packet_ctrl

Sequences the PS/2 mouse for the whack-an-engineer game. It sends the enable-reporting command and checks the acknowledge, then assembles 3-byte movement packets into a clamped on-screen cursor position and button state. It sits between the PS/2 byte-level transceiver and the cursor/VGA and hex-display logic.

## Interface

Parameters:
- X_MAX, 319: largest cursor x (inclusive).
- Y_MAX, 239: largest cursor y (inclusive).
- X_INIT, 160: cursor x after reset.
- Y_INIT, 120: cursor y after reset.
- TIMEOUT, 100000: idle-cycle limit, used only with MOUSE_TIMEOUT_EN.

Ports:
- CLOCK_50, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- rx_data, input, 8: byte received from the transceiver.
- rx_valid, input, 1: one-cycle strobe; rx_data is valid in that cycle.
- tx_busy, input, 1: transceiver is transmitting.
- tx_cmd, output, 8: command byte; constant 8'hF4.
- tx_send, output, 1: one-cycle request to transmit tx_cmd.
- x, output, 9: cursor x, range 0..X_MAX.
- y, output, 9: cursor y, range 0..Y_MAX; screen-down is positive.
- left_click, output, 1: left button level.
- right_click, output, 1: right button level.
- pkt_valid, output, 1: one-cycle pulse when a packet is applied.
- cState, output, 2: controller state, for LED display.

## Operation

State machine, with cState encoding:
- SEND (2'b00): when tx_busy=0, pulse tx_send for 1 cycle and go to ACK. When tx_busy=1, wait.
- ACK (2'b01): on rx_valid, 8'hFA goes to STREAM; any other byte goes to SEND (resend).
- STREAM (2'b10): assembles packets. Received byte 8'hAA (mouse self-test/hot-plug) goes to SEND when the byte index is 0.
- 2'b11: unused; if ever reached, go to SEND.
- rx_valid in SEND is ignored.

Packet assembly in STREAM:
- A 2-bit byte index runs 0, 1, 2, 0, and so on.
- Byte 0 is accepted only if bit3=1. Otherwise it is dropped and the index stays 0 (resync).
- Byte 0 fields: b0=left, b1=right, b4=X sign, b5=Y sign, b6=X overflow, b7=Y overflow.
- dx = {Xsign, byte1} and dy = {Ysign, byte2}, both 9-bit two's complement.
- On byte 2:
  - nx = x + dx and ny = y - dy, both computed in 11-bit signed.
  - Each result is clamped to [0, MAX].
  - If either overflow bit is set, x and y are held; buttons still update.
- left_click, right_click, x and y update together, and pkt_valid pulses in the same cycle.

Reset values:
- Outputs: cState=SEND, tx_send=0, x=X_INIT, y=Y_INIT, left_click=0, right_click=0, pkt_valid=0.
- Internal: byte index 0.

Reset mid-packet discards the partial packet and restarts the init sequence. The first tx_send comes one cycle after reset deasserts, if tx_busy=0.

## Timing

- tx_send is asserted in the first SEND cycle with tx_busy=0. The state is ACK in the following cycle.
- ACK to STREAM takes 1 cycle after the rx_valid carrying 8'hFA.
- Packet latency: x, y, buttons and pkt_valid are registered on the cycle after the byte-2 rx_valid (1-cycle latency).
- Back-to-back rx_valid on consecutive cycles must be accepted with no loss.
- Clamp boundaries:
  - x=X_MAX with dx>0 stays X_MAX.
  - x=0 with dx=-256 stays 0.
  - No wrap-around ever occurs.

## Configuration

MOUSE_TIMEOUT_EN.

Defined:
- A 17-bit idle counter clears on every rx_valid and on every state change.
- It increments while in ACK, or while in STREAM with byte index ≠ 0.
- On reaching TIMEOUT, ACK returns to SEND.
- In STREAM, the byte index returns to 0 and the partial packet is discarded. x and y are unchanged and no pkt_valid is generated.

Undefined:
- No counter exists.
- ACK and partial packets wait indefinitely.

## Test plan

- Init: reset, tx_busy=0 → tx_send pulse, cState=01; send 8'hFA → cState=10.
- Bad ack: in ACK, send 8'hFE → cState=00, then a new tx_send pulse.
- Packet: bytes 08, 05, 03 from (160,120) → x=165, y=117, pkt_valid pulse 1 cycle after byte 2.
- Clamp and negative: packet 09, 7F, 00 repeated 3 times → x=319 and left_click=1. Then packet 18, 00, 00 (dx=-256) twice → x=0, left_click=0.
- Resync/overflow: stray byte 8'h00 at index 0 is dropped, and the next valid packet applies normally. Packet 48, 10, 10 → x and y unchanged, pkt_valid=1.
- With MOUSE_TIMEOUT_EN and TIMEOUT=100: send 08, 05, then idle 100 cycles, then 08, 01, 01 → x=161, not 165+; single pkt_valid.
